// File: rtl/fp_pkg.sv
// Shared definitions for the single-precision rounding/packing datapath:
// rounding modes, fflags bit positions and binary32 constants.
package fp_pkg;

    typedef enum logic [2:0] {
        RM_RNE = 3'b000,
        RM_RTZ = 3'b001,
        RM_RDN = 3'b010,
        RM_RUP = 3'b011,
        RM_RMM = 3'b100
    } rm_e;

    localparam int FF_NV = 4;
    localparam int FF_DZ = 3;
    localparam int FF_OF = 2;
    localparam int FF_UF = 1;
    localparam int FF_NX = 0;

    localparam logic [31:0] FP_CANON_NAN  = 32'h7FC0_0000;
    localparam logic [31:0] FP_MAX_FINITE = 32'h7F7F_FFFF;
    localparam logic [7:0]  FP_EXP_MAX    = 8'hFF;

endpackage

// File: rtl/fp_round_inc.sv
// Rounding decision: from mode, sign, fraction lsb and guard/round/sticky,
// decide whether to add one ulp and whether the result is inexact.
module fp_round_inc
    import fp_pkg::*;
(
    input  logic [2:0] rm,
    input  logic       sign,
    input  logic       lsb,
    input  logic [2:0] grs,
    output logic       inc,
    output logic       inexact
);

    logic g;
    logic rs;

    assign g  = grs[2];
    assign rs = grs[1] | grs[0];

    // Per-mode increment decision; reserved codes round to nearest-even
    always_comb begin
        inexact = g | rs;
        inc     = 1'b0;
        case (rm)
            RM_RTZ:  inc = 1'b0;
            RM_RDN:  inc = sign & inexact;
            RM_RUP:  inc = ~sign & inexact;
            RM_RMM:  inc = g;
            default: inc = g & (rs | lsb);
        endcase
    end

endmodule

// File: rtl/fp_round_pack.sv
// Round and pack stage: S1 captures the rounding decision, S2 registers the
// packed binary32 word. Flags exist only when FP_ROUND_FLAGS_EN is defined.
module fp_round_pack
    import fp_pkg::*;
#(
    parameter bit LATENCY_REG_OUT = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [7:0]  in_exp,
    input  logic [22:0] in_mant,
    input  logic [2:0]  in_grs,
    input  logic        in_underflow,
    input  logic        in_nan,
    input  logic        in_inf,
    input  logic [2:0]  in_rm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [4:0]  out_fflags
);

    logic        s2_ready;
    logic        in_fire;
    logic        dec_inc;

    logic        s1_valid;
    logic        s1_sign;
    logic [7:0]  s1_exp;
    logic [22:0] s1_mant;
    logic        s1_inc;
    logic        s1_uf;
    logic        s1_nan;
    logic        s1_inf;
    logic [2:0]  s1_rm;

    logic [23:0] sum;
    logic [7:0]  exp_r;
    logic        ovf;
    logic        to_max;
    logic [31:0] res_word;

`ifdef FP_ROUND_FLAGS_EN
    logic        dec_nx;
    logic        s1_nx;
    logic [4:0]  res_flags;
`endif

    assign in_ready = flush | ~s1_valid | s2_ready;
    assign in_fire  = in_valid & in_ready & ~flush;

    fp_round_inc u_inc (
        .rm      (in_rm),
        .sign    (in_sign),
        .lsb     (in_mant[0]),
        .grs     (in_grs),
        .inc     (dec_inc),
`ifdef FP_ROUND_FLAGS_EN
        .inexact (dec_nx)
`else
        .inexact ()
`endif
    );

    // S1: capture operand and rounding decision; flush kills only the valid
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_exp   <= '0;
            s1_mant  <= '0;
            s1_inc   <= 1'b0;
            s1_uf    <= 1'b0;
            s1_nan   <= 1'b0;
            s1_inf   <= 1'b0;
            s1_rm    <= '0;
`ifdef FP_ROUND_FLAGS_EN
            s1_nx    <= 1'b0;
`endif
        end else begin
            if (flush)
                s1_valid <= 1'b0;
            else if (in_ready)
                s1_valid <= in_valid;
            if (in_fire) begin
                s1_sign <= in_sign;
                s1_exp  <= in_exp;
                s1_mant <= in_mant;
                s1_inc  <= dec_inc;
                s1_uf   <= in_underflow;
                s1_nan  <= in_nan;
                s1_inf  <= in_inf;
                s1_rm   <= in_rm;
`ifdef FP_ROUND_FLAGS_EN
                s1_nx   <= dec_nx;
`endif
            end
        end
    end

    // Apply the increment, handle carry/overflow/specials and pack
    always_comb begin
        sum    = {1'b0, s1_mant} + {23'b0, s1_inc};
        exp_r  = s1_exp + {7'b0, sum[23]};
        ovf    = (exp_r == FP_EXP_MAX) | (s1_exp == FP_EXP_MAX);
        to_max = (s1_rm == RM_RTZ)
               | ((s1_rm == RM_RDN) & ~s1_sign)
               | ((s1_rm == RM_RUP) & s1_sign);
        res_word = {s1_sign, exp_r, sum[22:0]};
        if (s1_nan)
            res_word = FP_CANON_NAN;
        else if (s1_inf)
            res_word = {s1_sign, FP_EXP_MAX, 23'h0};
        else if (s1_uf)
            res_word = {s1_sign, 31'h0};
        else if (ovf && to_max)
            res_word = {s1_sign, FP_MAX_FINITE[30:0]};
        else if (ovf)
            res_word = {s1_sign, FP_EXP_MAX, 23'h0};
    end

`ifdef FP_ROUND_FLAGS_EN
    // Exception flags matching the result selection above
    always_comb begin
        res_flags = '0;
        if (!s1_nan && !s1_inf) begin
            if (s1_uf) begin
                res_flags[FF_UF] = 1'b1;
                res_flags[FF_NX] = 1'b1;
            end else if (ovf) begin
                res_flags[FF_OF] = 1'b1;
                res_flags[FF_NX] = 1'b1;
            end else begin
                res_flags[FF_UF] = s1_nx & (s1_exp == 8'h00);
                res_flags[FF_NX] = s1_nx;
            end
        end
    end
`else
    assign out_fflags = '0;
`endif

    if (LATENCY_REG_OUT) begin : g_reg
        logic        s2_valid;
        logic [31:0] s2_res;
`ifdef FP_ROUND_FLAGS_EN
        logic [4:0]  s2_flags;
`endif

        assign s2_ready   = ~s2_valid | out_ready;
        assign out_valid  = s2_valid;
        assign out_result = s2_res;
`ifdef FP_ROUND_FLAGS_EN
        assign out_fflags = s2_flags;
`endif

        // S2: output register, held while the consumer stalls
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                s2_valid <= 1'b0;
                s2_res   <= '0;
`ifdef FP_ROUND_FLAGS_EN
                s2_flags <= '0;
`endif
            end else begin
                if (flush)
                    s2_valid <= 1'b0;
                else if (s2_ready)
                    s2_valid <= s1_valid;
                if (s1_valid && s2_ready) begin
                    s2_res   <= res_word;
`ifdef FP_ROUND_FLAGS_EN
                    s2_flags <= res_flags;
`endif
                end
            end
        end
    end else begin : g_comb
        assign s2_ready   = out_ready;
        assign out_valid  = s1_valid;
        assign out_result = res_word;
`ifdef FP_ROUND_FLAGS_EN
        assign out_fflags = res_flags;
`endif
    end

endmodule
